// File: rtl/iob_byte_packer_pkg.sv
// Shared types, defaults and helpers for the byte-to-word packer.
// Optional running-max feature is enabled by IOB_BYTE_PACKER_MAX_EN.
package iob_byte_packer_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_BYTE_W = 8;
   localparam int N_BYTES    = DEF_DATA_W / DEF_BYTE_W;
   localparam int CNT_W      = $clog2(N_BYTES + 1);

   function automatic logic [DEF_BYTE_W-1:0] iob_max(
      input logic [DEF_BYTE_W-1:0] a,
      input logic [DEF_BYTE_W-1:0] b
   );
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/iob_byte_packer_if.sv
// Byte-in / word-out valid-ready bundle for the packer.
// slave = packer side, master = producer/consumer side.
interface iob_byte_packer_if
   import iob_byte_packer_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int BYTE_W = DEF_BYTE_W,
   parameter int CW     = $clog2(DATA_W / BYTE_W + 1)
);

   logic              byte_valid_i;
   logic [BYTE_W-1:0] byte_data_i;
   logic              byte_ready_o;
   logic              word_valid_o;
   logic [DATA_W-1:0] word_data_o;
   logic [CW-1:0]     word_nbytes_o;
   logic [BYTE_W-1:0] word_max_o;
   logic              word_ready_i;

   modport slave (
      input  byte_valid_i,
      input  byte_data_i,
      output byte_ready_o,
      output word_valid_o,
      output word_data_o,
      output word_nbytes_o,
      output word_max_o,
      input  word_ready_i
   );

   modport master (
      output byte_valid_i,
      output byte_data_i,
      input  byte_ready_o,
      input  word_valid_o,
      input  word_data_o,
      input  word_nbytes_o,
      input  word_max_o,
      output word_ready_i
   );

endinterface

// File: rtl/iob_byte_packer_outreg.sv
// Output word register: loads a packed word and holds it until taken.
// Optional max field travels with the word (IOB_BYTE_PACKER_MAX_EN).
module iob_byte_packer_outreg
   import iob_byte_packer_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int BYTE_W = DEF_BYTE_W,
   parameter int CW     = CNT_W
) (
   input  logic              clk,
   input  logic              arst_n,
   input  logic              i_clear,
   input  logic              i_load,
   input  logic              i_ready,
   input  logic [DATA_W-1:0] i_data,
   input  logic [CW-1:0]     i_nbytes,
   input  logic [BYTE_W-1:0] i_max,
   output logic              o_valid,
   output logic [DATA_W-1:0] o_data,
   output logic [CW-1:0]     o_nbytes,
   output logic [BYTE_W-1:0] o_max
);

   logic              r_valid;
   logic [DATA_W-1:0] r_data;
   logic [CW-1:0]     r_nbytes;
   logic [BYTE_W-1:0] r_max;

   // A load only happens when the register is free, so held data never moves
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_valid  <= 1'b0;
         r_data   <= '0;
         r_nbytes <= '0;
         r_max    <= '0;
      end else if (i_clear) begin
         r_valid  <= 1'b0;
         r_data   <= '0;
         r_nbytes <= '0;
         r_max    <= '0;
      end else if (i_load) begin
         r_valid  <= 1'b1;
         r_data   <= i_data;
         r_nbytes <= i_nbytes;
         r_max    <= i_max;
      end else if (r_valid && i_ready) begin
         r_valid  <= 1'b0;
      end
   end

   assign o_valid  = r_valid;
   assign o_data   = r_data;
   assign o_nbytes = r_nbytes;
   assign o_max    = r_max;

endmodule

// File: rtl/iob_byte_packer.sv
// Streaming byte-to-word packer, first byte in the MSBs, one byte/cycle.
// Define IOB_BYTE_PACKER_MAX_EN to track the max byte of each word.
module iob_byte_packer
   import iob_byte_packer_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int BYTE_W = DEF_BYTE_W
) (
   input  logic              clk,
   input  logic              arst_n,
   input  logic              clear_i,
   input  logic              flush_i,
   iob_byte_packer_if.slave  bus
);

   localparam int NB = DATA_W / BYTE_W;
   localparam int CW = $clog2(NB + 1);

   logic [CW-1:0]     r_cnt;
   logic [DATA_W-1:0] r_acc;

   logic              w_valid;
   logic              w_out_free;
   logic              w_ready;
   logic              w_take;
   logic              w_last;
   logic              w_flush;
   logic              w_load;
   logic [DATA_W-1:0] w_acc_nxt;
   logic [DATA_W-1:0] w_ld_data;
   logic [CW-1:0]     w_ld_nbytes;
   logic [BYTE_W-1:0] w_ld_max;

   assign w_out_free = !w_valid || bus.word_ready_i;
   assign w_ready    = !clear_i && !flush_i &&
                       ((r_cnt < CW'(NB - 1)) || w_out_free);
   assign w_take     = bus.byte_valid_i && w_ready;
   assign w_last     = w_take && (r_cnt == CW'(NB - 1));
   assign w_flush    = !clear_i && flush_i &&
                       (r_cnt != '0) && w_out_free;
   assign w_load     = w_last || w_flush;

   always_comb begin
      w_acc_nxt = r_acc;
      for (int i = 0; i < NB; i++) begin
         if (r_cnt == CW'(i))
            w_acc_nxt[DATA_W-1-BYTE_W*i -: BYTE_W] = bus.byte_data_i;
      end
   end

   // On the last byte the freshly merged accumulator is the word itself
   assign w_ld_data   = w_last ? w_acc_nxt : r_acc;
   assign w_ld_nbytes = w_last ? CW'(NB) : r_cnt;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_cnt <= '0;
         r_acc <= '0;
      end else if (clear_i || w_load) begin
         r_cnt <= '0;
         r_acc <= '0;
      end else if (w_take) begin
         r_cnt <= r_cnt + 1'b1;
         r_acc <= w_acc_nxt;
      end
   end

`ifdef IOB_BYTE_PACKER_MAX_EN
   logic [BYTE_W-1:0] r_max;
   logic [BYTE_W-1:0] w_max_nxt;

   assign w_max_nxt = iob_max(r_max, bus.byte_data_i);

   // Flush blocks bytes, so padding never reaches the tracker
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_max <= '0;
      end else if (clear_i || w_load) begin
         r_max <= '0;
      end else if (w_take) begin
         r_max <= w_max_nxt;
      end
   end

   assign w_ld_max = w_last ? w_max_nxt : r_max;
`else
   assign w_ld_max = '0;
`endif

   iob_byte_packer_outreg #(
      .DATA_W (DATA_W),
      .BYTE_W (BYTE_W),
      .CW     (CW)
   ) u_outreg (
      .clk      (clk),
      .arst_n   (arst_n),
      .i_clear  (clear_i),
      .i_load   (w_load),
      .i_ready  (bus.word_ready_i),
      .i_data   (w_ld_data),
      .i_nbytes (w_ld_nbytes),
      .i_max    (w_ld_max),
      .o_valid  (w_valid),
      .o_data   (bus.word_data_o),
      .o_nbytes (bus.word_nbytes_o),
      .o_max    (bus.word_max_o)
   );

   assign bus.word_valid_o = w_valid;
   assign bus.byte_ready_o = w_ready;

endmodule

// File: tb/tb_iob_byte_packer.sv
// Directed self-checking bench for iob_byte_packer.
// Expected max follows IOB_BYTE_PACKER_MAX_EN.
module tb_iob_byte_packer;
   import iob_byte_packer_pkg::*;

`ifdef IOB_BYTE_PACKER_MAX_EN
   localparam bit MAX_EN = 1'b1;
`else
   localparam bit MAX_EN = 1'b0;
`endif

   logic clk     = 1'b0;
   logic arst_n  = 1'b0;
   logic clear_i = 1'b0;
   logic flush_i = 1'b0;

   iob_byte_packer_if bus ();

   iob_byte_packer dut (
      .clk     (clk),
      .arst_n  (arst_n),
      .clear_i (clear_i),
      .flush_i (flush_i),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag,
                      input logic [63:0] obs,
                      input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] emax(input logic [7:0] m);
      return MAX_EN ? m : 8'h00;
   endfunction

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   // Offer one byte until accepted; returns the number of stalled cycles
   task automatic push(input logic [7:0] b, output int st);
      bit r;
      st = 0;
      bus.byte_valid_i = 1'b1;
      bus.byte_data_i  = b;
      forever begin
         @(negedge clk);
         r = bus.byte_ready_o;
         sync();
         if (r) break;
         st++;
         if (st > 40) begin
            chk("push_timeout", 64'(st), 64'd0);
            break;
         end
      end
   endtask

   task automatic push_n(input logic [31:0] w, input int n, output int st);
      int s;
      st = 0;
      for (int i = 0; i < n; i++) begin
         push(w[31-8*i -: 8], s);
         st += s;
      end
      bus.byte_valid_i = 1'b0;
   endtask

   task automatic chk_word(input string tag, input logic [31:0] d,
                           input logic [2:0] nb, input logic [7:0] mx);
      chk({tag, "_valid"}, 64'(bus.word_valid_o), 64'd1);
      chk({tag, "_data"}, 64'(bus.word_data_o), 64'(d));
      chk({tag, "_nbytes"}, 64'(bus.word_nbytes_o), 64'(nb));
      chk({tag, "_max"}, 64'(bus.word_max_o), 64'(emax(mx)));
   endtask

   initial begin
      int st;
      bus.byte_valid_i = 1'b0;
      bus.byte_data_i  = '0;
      bus.word_ready_i = 1'b0;

      #2;
      chk("rst_valid", 64'(bus.word_valid_o), 64'd0);
      chk("rst_data", 64'(bus.word_data_o), 64'd0);
      chk("rst_nbytes", 64'(bus.word_nbytes_o), 64'd0);
      chk("rst_max", 64'(bus.word_max_o), 64'd0);
      sync();
      sync();
      arst_n = 1'b1;
      @(negedge clk);
      chk("rst_ready", 64'(bus.byte_ready_o), 64'd1);
      sync();

      // Back-to-back stream, consumer always ready
      bus.word_ready_i = 1'b1;
      push_n(32'h11223344, 4, st);
      chk("t2_stalls", 64'(st), 64'd0);
      @(negedge clk);
      chk_word("t2", 32'h11223344, 3'd4, 8'h44);
      sync();
      @(negedge clk);
      chk("t2_drained", 64'(bus.word_valid_o), 64'd0);
      sync();

      // Backpressure: first word held, 8th byte blocked at cnt==3
      bus.word_ready_i = 1'b0;
      push_n(32'hA1B2C3D4, 4, st);
      push_n(32'h01020300, 3, st);
      chk("t3_partial_stalls", 64'(st), 64'd0);
      bus.byte_valid_i = 1'b1;
      bus.byte_data_i  = 8'h04;
      @(negedge clk);
      chk("t3_blocked", 64'(bus.byte_ready_o), 64'd0);
      chk_word("t3_held", 32'hA1B2C3D4, 3'd4, 8'hD4);
      sync();
      @(negedge clk);
      chk("t3_blocked2", 64'(bus.byte_ready_o), 64'd0);
      chk("t3_stable", 64'(bus.word_data_o), 64'hA1B2C3D4);
      bus.word_ready_i = 1'b1;
      #1;
      chk("t3_ready_drain", 64'(bus.byte_ready_o), 64'd1);
      sync();
      bus.word_ready_i = 1'b0;
      bus.byte_valid_i = 1'b0;
      @(negedge clk);
      chk_word("t3_second", 32'h01020304, 3'd4, 8'h04);
      bus.word_ready_i = 1'b1;
      sync();
      @(negedge clk);
      chk("t3_drained", 64'(bus.word_valid_o), 64'd0);
      sync();

      // Flush of a two-byte partial word
      push_n(32'h7F800000, 2, st);
      flush_i = 1'b1;
      bus.byte_valid_i = 1'b1;
      bus.byte_data_i  = 8'h55;
      @(negedge clk);
      chk("t4_flush_blocks", 64'(bus.byte_ready_o), 64'd0);
      sync();
      flush_i = 1'b0;
      bus.byte_valid_i = 1'b0;
      @(negedge clk);
      chk_word("t4", 32'h7F800000, 3'd2, 8'h80);
      sync();

      // Flush with nothing collected does nothing
      flush_i = 1'b1;
      sync();
      flush_i = 1'b0;
      @(negedge clk);
      chk("t4_noop", 64'(bus.word_valid_o), 64'd0);
      sync();

      // Clear drops held word and partial bytes
      bus.word_ready_i = 1'b0;
      push_n(32'h55667788, 4, st);
      push_n(32'h99AA0000, 2, st);
      @(negedge clk);
      chk("t5_held", 64'(bus.word_valid_o), 64'd1);
      clear_i = 1'b1;
      #1;
      chk("t5_clear_blocks", 64'(bus.byte_ready_o), 64'd0);
      sync();
      clear_i = 1'b0;
      @(negedge clk);
      chk("t5_cleared", 64'(bus.word_valid_o), 64'd0);
      sync();
      bus.word_ready_i = 1'b1;
      push_n(32'h010203FE, 4, st);
      @(negedge clk);
      chk_word("t5", 32'h010203FE, 3'd4, 8'hFE);
      sync();

      // Async reset mid-stream with a held word and a partial byte
      bus.word_ready_i = 1'b0;
      push_n(32'h12345678, 4, st);
      push_n(32'h9A000000, 1, st);
      @(negedge clk);
      chk("t1_held", 64'(bus.word_valid_o), 64'd1);
      #2;
      arst_n = 1'b0;
      #1;
      chk("t1_rst_valid", 64'(bus.word_valid_o), 64'd0);
      chk("t1_rst_data", 64'(bus.word_data_o), 64'd0);
      chk("t1_rst_nbytes", 64'(bus.word_nbytes_o), 64'd0);
      chk("t1_rst_max", 64'(bus.word_max_o), 64'd0);
      #1;
      arst_n = 1'b1;
      bus.word_ready_i = 1'b1;
      #0;
      chk("t1_ready_after", 64'(bus.byte_ready_o), 64'd1);
      sync();
      chk("t1_no_emit", 64'(bus.word_valid_o), 64'd0);
      push_n(32'hBCDEF00F, 4, st);
      @(negedge clk);
      chk_word("t1_fresh", 32'hBCDEF00F, 3'd4, 8'hF0);
      sync();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_err);
      $finish;
   end

endmodule
